// File: rtl/mips_ex_mem_unit.sv
// EX + MEM slice of a 5-stage MIPS pipeline: decode, ALU, branch/jump resolve,
// EX/MEM register, 32-word data memory. Optional macro: DMEM_READ_GATE_EN.
module mips_ex_mem_unit (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic [4:0]  wreg_in,
    input  logic        regwrite_in,
    input  logic        flush,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        branch_taken,
    output logic        jump,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_en
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic       alu_src, mem_read, mem_write, mem_to_reg, branch, j_to_pc;
    logic [3:0] alu_op;

    always_comb begin
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        j_to_pc    = 1'b0;
        alu_op     = ALU_ADD;
        case (op)
            6'h00: begin
                case (funct)
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h27:   alu_op = ALU_NOR;
                    6'h2A:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            6'h08: alu_src = 1'b1;
            6'h0C: begin alu_src = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin alu_src = 1'b1; alu_op = ALU_OR;  end
            6'h0A: begin alu_src = 1'b1; alu_op = ALU_SLT; end
            6'h23: begin alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; end
            6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; end
            6'h04: begin branch = 1'b1; alu_op = ALU_SUB; end
            6'h02: j_to_pc = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] opb;
    assign opb = alu_src ? imm : rt_data;

    always_comb begin
        case (alu_op)
            ALU_AND: alu_result = rs_data & opb;
            ALU_OR:  alu_result = rs_data | opb;
            ALU_ADD: alu_result = rs_data + opb;
            ALU_SUB: alu_result = rs_data - opb;
            ALU_SLT: alu_result = {31'd0, $signed(rs_data) < $signed(opb)};
            ALU_NOR: alu_result = ~(rs_data | opb);
            default: alu_result = 32'd0;
        endcase
    end

    assign zero         = (alu_result == 32'd0);
    assign branch_taken = branch & zero;
    assign jump         = j_to_pc;

    logic [31:0] alu_result_q, rt_data_q;
    logic        mem_write_q, mem_to_reg_q, regwrite_q;
    logic [4:0]  wreg_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_q <= 32'd0;
            rt_data_q    <= 32'd0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            regwrite_q   <= 1'b0;
            wreg_q       <= 5'd0;
        end else begin
            alu_result_q <= alu_result;
            rt_data_q    <= rt_data;
            mem_write_q  <= mem_write & ~flush;
            mem_to_reg_q <= mem_to_reg & ~flush;
            regwrite_q   <= regwrite_in & ~flush;
            wreg_q       <= wreg_in;
        end
    end

    // Flop-based memory: reset must clear every word asynchronously.
    logic [31:0] mem_q [32];
    logic [4:0]  mem_idx;
    assign mem_idx = alu_result_q[6:2];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_word
            always_ff @(posedge CLK or negedge reset_n) begin
                if (!reset_n)
                    mem_q[gi] <= 32'd0;
                else if (mem_write_q && mem_idx == gi[4:0])
                    mem_q[gi] <= rt_data_q;
            end
        end
    endgenerate

    logic [31:0] mem_rd;
`ifdef DMEM_READ_GATE_EN
    logic mem_read_q;
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            mem_read_q <= 1'b0;
        else
            mem_read_q <= mem_read & ~flush;
    end
    assign mem_rd = mem_read_q ? mem_q[mem_idx] : 32'd0;
`else
    logic unused_mem_read;
    assign unused_mem_read = mem_read;
    assign mem_rd = mem_q[mem_idx];
`endif

    assign wb_data = mem_to_reg_q ? mem_rd : alu_result_q;
    assign wb_addr = wreg_q;
    assign wb_en   = regwrite_q;
endmodule

// File: tb/tb_mips_ex_mem_unit.sv
// Bench for mips_ex_mem_unit: directed plan steps plus randomized instructions
// checked against an instruction-level reference model.
module tb_mips_ex_mem_unit;
    logic        CLK = 1'b0;
    logic        reset_n;
    logic [5:0]  op, funct;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  wreg_in;
    logic        regwrite_in, flush;
    logic [31:0] alu_result, wb_data;
    logic        zero, branch_taken, jump, wb_en;
    logic [4:0]  wb_addr;

    int vectors = 0;
    int miscompares = 0;

    mips_ex_mem_unit dut (
        .CLK(CLK), .reset_n(reset_n), .op(op), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .wreg_in(wreg_in), .regwrite_in(regwrite_in), .flush(flush),
        .alu_result(alu_result), .zero(zero), .branch_taken(branch_taken),
        .jump(jump), .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en)
    );

    always #5 CLK = ~CLK;

    // Reference state: memory contents and the instruction sitting in MEM.
    logic [31:0] ref_mem [32];
    logic [31:0] st_res, st_store;
    logic        st_load, st_store_en, st_wen;
    logic [4:0]  st_wreg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Instruction semantics straight from the MIPS subset.
    function automatic void exec(input logic [5:0] o, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] i, output logic [31:0] r,
                                 output logic is_beq, output logic is_j,
                                 output logic is_lw, output logic is_sw);
        is_beq = (o == 6'h04);
        is_j   = (o == 6'h02);
        is_lw  = (o == 6'h23);
        is_sw  = (o == 6'h2B);
        case (o)
            6'h00: case (f)
                6'h22:   r = a - b;
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                6'h27:   r = ~(a | b);
                6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: r = a + b;
            endcase
            6'h08, 6'h23, 6'h2B: r = a + i;
            6'h0C: r = a & i;
            6'h0D: r = a | i;
            6'h0A: r = ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
            6'h04: r = a - b;
            default: r = a + b;
        endcase
    endfunction

    function automatic logic [31:0] exp_wb();
        return st_load ? ref_mem[st_res[6:2]] : st_res;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) ref_mem[k] = 32'd0;
        st_res = 0; st_store = 0; st_load = 0; st_store_en = 0; st_wen = 0; st_wreg = 0;
    endtask

    task automatic check_wb();
        chk("wb_data", wb_data, exp_wb());
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, st_wreg});
        chk("wb_en", {31'd0, wb_en}, {31'd0, st_wen});
    endtask

    task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i, input logic [4:0] w,
                         input logic rw, input logic fl);
        logic [31:0] r;
        logic is_beq, is_j, is_lw, is_sw;
        op = o; funct = f; rs_data = a; rt_data = b; imm = i;
        wreg_in = w; regwrite_in = rw; flush = fl;
        exec(o, f, a, b, i, r, is_beq, is_j, is_lw, is_sw);
        #1;
        chk("alu_result", alu_result, r);
        chk("zero", {31'd0, zero}, {31'd0, r == 32'd0});
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, is_beq && r == 32'd0});
        chk("jump", {31'd0, jump}, {31'd0, is_j});
        @(posedge CLK);
        if (st_store_en) ref_mem[st_res[6:2]] = st_store;
        st_res = r; st_store = b; st_wreg = w;
        st_load = is_lw & ~fl; st_store_en = is_sw & ~fl; st_wen = rw & ~fl;
        #1;
        check_wb();
    endtask

    localparam int NOPS = 10;
    logic [5:0] op_tab [NOPS] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    initial begin
        reset_n = 1'b0; op = 0; funct = 0; rs_data = 0; rt_data = 0; imm = 0;
        wreg_in = 0; regwrite_in = 0; flush = 0;
        model_reset();
        #12;
        check_wb();
        reset_n = 1'b1;
        @(posedge CLK); #1;

        // Directed steps from the plan
        apply(6'h00, 6'h20, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0);
        apply(6'h2B, 6'h00, 32'd0, 32'hDEADBEEF, 32'd8, 5'd0, 1'b0, 1'b0);
        apply(6'h23, 6'h00, 32'd4, 32'd0, 32'd4, 5'd9, 1'b1, 1'b0);
        chk("lw_after_sw", wb_data, 32'hDEADBEEF);
        apply(6'h04, 6'h00, 32'h1234, 32'h1234, 32'd0, 5'd0, 1'b0, 1'b0);
        apply(6'h04, 6'h00, 32'h1234, 32'h1235, 32'd0, 5'd0, 1'b0, 1'b0);
        apply(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd4, 1'b1, 1'b0);
        apply(6'h00, 6'h2A, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd4, 1'b1, 1'b0);
        apply(6'h00, 6'h22, 32'd0, 32'd1, 32'd0, 5'd5, 1'b1, 1'b0);
        apply(6'h02, 6'h00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        apply(6'h2B, 6'h00, 32'd0, 32'h55AA55AA, 32'd8, 5'd0, 1'b0, 1'b1);
        apply(6'h23, 6'h00, 32'd0, 32'd0, 32'd8, 5'd7, 1'b1, 1'b0);
        chk("flushed_sw", wb_data, 32'hDEADBEEF);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            logic [31:0] a, b, i;
            o = op_tab[$urandom_range(NOPS - 1)];
            f = ($urandom_range(7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(5)];
            a = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(16) - 8);
            b = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(16) - 8);
            i = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(256) - 128);
            if (o == 6'h04 && $urandom_range(1) == 0) b = a;
            apply(o, f, a, b, i, 5'($urandom), 1'($urandom), $urandom_range(7) == 0);
        end

        // Store then load, then reset asynchronously mid-cycle
        apply(6'h2B, 6'h00, 32'd12, 32'hCAFEF00D, 32'd0, 5'd0, 1'b0, 1'b0);
        apply(6'h23, 6'h00, 32'd12, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0);
        chk("lw_before_reset", wb_data, 32'hCAFEF00D);
        apply(6'h2B, 6'h00, 32'd16, 32'h0BADBEEF, 32'd0, 5'd0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_wb();
        @(posedge CLK); #1;
        check_wb();
        reset_n = 1'b1;
        #2;
        apply(6'h23, 6'h00, 32'd12, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0);
        chk("lw_after_reset", wb_data, 32'd0);
        apply(6'h23, 6'h00, 32'd16, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++)
            apply(6'h23, 6'h00, $urandom, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mips_ex_mem_unit.md
# mips_ex_mem_unit

Execute-plus-memory slice of the 5-stage MIPS pipeline. It decodes opcode/funct into datapath controls, performs the ALU operation and resolves branch/jump in EX. It registers the result into an internal EX/MEM stage, accesses a 32-word data memory, and presents write-back data to the MEM/WB pipe. It sits between the ID/EX pipe register and the MEM/WB pipe register.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- rs_data  in  32  ALU operand A.
- rt_data  in  32  operand B when ALUSrc=0; store data.
- imm  in  32  already sign-extended immediate.
- wreg_in  in  5  destination register from ID.
- regwrite_in  in  1  write-enable from ID.
- flush  in  1  turn the EX instruction into a bubble.
- alu_result  out  32  EX-stage ALU result (combinational).
- zero  out  1  alu_result == 0.
- branch_taken  out  1  beq AND zero.
- jump  out  1  opcode is j.
- wb_data  out  32  MEM-stage write-back data.
- wb_addr  out  5  registered wreg_in.
- wb_en  out  1  registered regwrite_in.

## Operation
- Control decode (combinational) produces ALUSrc, MemRead, MemWrite, MemtoReg, Branch, JtoPC and a 4-bit ALUOp.
  - R-type (op=0): funct 0x20 add→0010; 0x22 sub→0110; 0x24 and→0000; 0x25 or→0001; 0x27 nor→1100; 0x2A slt→0111. ALUSrc=0. Any other funct→add.
  - addi 0x08→add, ALUSrc=1.
  - andi 0x0C→and, ALUSrc=1.
  - ori 0x0D→or, ALUSrc=1.
  - slti 0x0A→slt, ALUSrc=1.
  - lw 0x23: add, ALUSrc=1, MemRead=1, MemtoReg=1.
  - sw 0x2B: add, ALUSrc=1, MemWrite=1.
  - beq 0x04: sub, ALUSrc=0, Branch=1.
  - j 0x02: JtoPC=1, ALUOp add.
  - Unknown opcode: all controls 0, ALUOp add.
- ALU
  - Operands: A=rs_data; B = ALUSrc ? imm : rt_data.
  - add/sub wrap modulo 2^32; overflow is ignored.
  - slt is signed and yields 1 or 0.
  - Unused ALUOp codes yield 0.
- Branch and jump
  - branch_taken = Branch & zero.
  - jump = JtoPC.
  - Both are combinational; target computation is outside this block.
- EX/MEM register
  - Captures alu_result, rt_data, MemRead, MemWrite, MemtoReg, wreg_in and regwrite_in.
  - When flush=1, MemRead, MemWrite, MemtoReg and regwrite are captured as 0.
- Data memory
  - 32 x 32-bit words, indexed by registered alu_result[6:2]; bits [1:0] are ignored, and address bits above [6] are ignored (wrap).
  - Write on the rising edge when MemWrite_q=1.
  - Read is combinational.
- wb_data = MemtoReg_q ? mem_word : alu_result_q.

## Timing
- Decode, ALU, zero, branch_taken and jump are combinational from the EX inputs, with zero cycles of latency.
- EX/MEM register updates on the rising CLK edge. wb_data, wb_addr and wb_en are valid for one cycle after the edge that captured the instruction.
- A store in MEM writes memory at the following edge. A load whose MEM cycle directly follows a store to the same word reads the new data.
- Reset asserted (at any time, including mid-store):
  - Clears all EX/MEM state immediately, so wb_data=0, wb_addr=0, wb_en=0.
  - Clears all memory words to 0.
  - Blocks all writes while asserted.
- flush and a valid sw in the same cycle: the store is suppressed.

## Configuration
- DMEM_READ_GATE_EN:
  - Defined: the memory read port returns 0 when MemRead_q=0.
  - Undefined: the read port always returns the addressed word.
  - wb_data is identical in both builds. Only the internal read bus and power differ.

## Test plan
- add: op=0, funct=0x20, rs=5, rt=7, regwrite_in=1, wreg_in=3 → alu_result=12 and zero=0. Next cycle: wb_data=12, wb_addr=3, wb_en=1.
- sw then lw: sw with rs=0, imm=8, rt=0xDEADBEEF. Next cycle lw with rs=4, imm=4 → wb_data=0xDEADBEEF in the lw MEM cycle.
- beq: rs=rt=0x1234 → zero=1, branch_taken=1. With rt=0x1235 → branch_taken=0.
- slt: rs=0xFFFFFFFF (-1), rt=1 → 1. Swapped operands → 0. sub of 0 minus 1 → 0xFFFFFFFF.
- j: op=2 → jump=1. Memory unchanged and wb_en=0 next cycle.
- flush and reset: sw with flush=1 → memory word unchanged. reset_n low mid-cycle after lw → wb_data and wb_en go to 0 immediately, and a subsequent lw of any address returns 0.
